mem_port_arbiter: RTL and testbench

Two-master arbiter placed directly upstream of the core memory controller. It merges the core's data port (master 0) and instruction-fetch port (master 1) onto the single req/gnt/rvalid memory port. It grants round-robin, records the owner of every granted transaction in order, and steers each rvalid back to the master that issued it.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_owner_fifo.sv | 72 +++++++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef logic master_id_t;

  localparam master_id_t MST_DATA  = 1'b0;
  localparam master_id_t MST_INSTR = 1'b1;

  // With two masters, "the other one" is simply the complement.
  function automatic master_id_t other_master(input master_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// In-order record of which master owns each granted transaction.
// Push and pop may happen together, including when the FIFO is full.
module mem_arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push,
  input  logic       pop,
  input  master_id_t din,
  output master_id_t dout,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  master_id_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after it has been written, as tracked by the reset count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin merge of the data and instruction-fetch ports onto one
// req/gnt/rvalid memory port, with in-order response steering.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NUM_MASTERS-1:0]                    m_req_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]    m_addr_i,
  input  logic [NUM_MASTERS-1:0]                    m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]  m_be_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]    m_wdata_i,
  output logic [NUM_MASTERS-1:0]                    m_gnt_o,
  output logic [NUM_MASTERS-1:0]                    m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                     m_rdata_o,
  output logic                                      s_req_o,
  output logic [ADDR_WIDTH-1:0]                     s_addr_o,
  output logic                                      s_we_o,
  output logic [DATA_WIDTH/8-1:0]                   s_be_o,
  output logic [DATA_WIDTH-1:0]                     s_wdata_o,
  input  logic                                      s_gnt_i,
  input  logic                                      s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                     s_rdata_i,
  output logic                                      err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  master_id_t prio_q;     // master that wins the next tie
  master_id_t sel;
  master_id_t fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       handshake;
  logic       rsp_ok;
  logic       err_q;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sel = MST_DATA;
    case (m_req_i)
      2'b01:   sel = MST_DATA;
      2'b10:   sel = MST_INSTR;
      2'b11:   sel = prio_q;
      default: sel = MST_DATA;
    endcase
  end

  // Full blocks new requests even if a response frees a slot this cycle,
  // keeping s_req_o independent of s_gnt_i and s_rvalid_i.
  assign s_req_o   = (|m_req_i) & ~fifo_full;
  assign handshake = s_req_o & s_gnt_i;

  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      s_addr_o  = m_addr_i[sel];
      s_we_o    = m_we_i[sel];
      s_be_o    = m_be_i[sel];
      s_wdata_o = m_wdata_i[sel];
    end
  end

  always_comb begin
    m_gnt_o = '0;
    if (handshake) begin
      m_gnt_o[sel] = 1'b1;
    end
  end

  // Responses return in grant order, so the FIFO head names their owner.
  assign rsp_ok    = s_rvalid_i & ~fifo_empty;
  assign m_rdata_o = s_rdata_i;

  always_comb begin
    m_rvalid_o = '0;
    if (rsp_ok) begin
      m_rvalid_o[fifo_head] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= MST_DATA;
      err_q  <= 1'b0;
    end else begin
      if (handshake) begin
        prio_q <= other_master(sel);
      end
      if (s_rvalid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

  mem_arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .pop    (rsp_ok),
    .din    (sel),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Keeps BE_WIDTH tied to the port declaration it documents.
  if (BE_WIDTH * 8 != DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a queue-based
// model of grant order, tie-breaking and response ownership.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;

  logic                clk;
  logic                rst_ni;
  logic [1:0]          m_req_i;
  logic [1:0][AW-1:0]  m_addr_i;
  logic [1:0]          m_we_i;
  logic [1:0][BW-1:0]  m_be_i;
  logic [1:0][DW-1:0]  m_wdata_i;
  logic [1:0]          m_gnt_o;
  logic [1:0]          m_rvalid_o;
  logic [DW-1:0]       m_rdata_o;
  logic                s_req_o;
  logic [AW-1:0]       s_addr_o;
  logic                s_we_o;
  logic [BW-1:0]       s_be_o;
  logic [DW-1:0]       s_wdata_o;
  logic                s_gnt_i;
  logic                s_rvalid_i;
  logic [DW-1:0]       s_rdata_i;
  logic                err_o;

  mem_port_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .m_req_i    (m_req_i),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_gnt_i    (s_gnt_i),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: owners of outstanding transactions, oldest first.
  int owner_q[$];
  int last_granted;   // -1 until the first grant after reset
  bit err_m;
  bit exp_hs;
  int exp_sel;
  bit exp_pop;
  bit exp_spur;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 2; i++) begin
      m_addr_i[i]  = $urandom;
      m_we_i[i]    = 1'($urandom);
      m_be_i[i]    = BW'($urandom);
      m_wdata_i[i] = $urandom;
    end
  endtask

  // Apply inputs for one cycle and check every output against the model.
  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [DW-1:0] rdata);
    bit       ereq;
    int       sel;
    logic [1:0] egnt;
    logic [1:0] ervalid;
    m_req_i    = req;
    s_gnt_i    = gnt;
    s_rvalid_i = rv;
    s_rdata_i  = rdata;
    #1;
    ereq = (req != 2'b00) && (owner_q.size() < MAXO);
    if (req == 2'b01)      sel = 0;
    else if (req == 2'b10) sel = 1;
    else                   sel = (last_granted == 0) ? 1 : 0;
    exp_hs   = ereq && gnt;
    exp_sel  = sel;
    exp_pop  = rv && (owner_q.size() > 0);
    exp_spur = rv && (owner_q.size() == 0);
    egnt     = exp_hs ? 2'(1 << sel) : 2'b00;
    ervalid  = exp_pop ? 2'(1 << owner_q[0]) : 2'b00;
    check("s_req",    s_req_o,    ereq);
    check("s_addr",   s_addr_o,   ereq ? m_addr_i[sel]  : '0);
    check("s_we",     s_we_o,     ereq ? m_we_i[sel]    : 1'b0);
    check("s_be",     s_be_o,     ereq ? m_be_i[sel]    : '0);
    check("s_wdata",  s_wdata_o,  ereq ? m_wdata_i[sel] : '0);
    check("m_gnt",    m_gnt_o,    egnt);
    check("m_rvalid", m_rvalid_o, ervalid);
    check("m_rdata",  m_rdata_o,  rdata);
    check("err",      err_o,      err_m);
  endtask

  task automatic advance();
    @(posedge clk);
    if (exp_pop)  void'(owner_q.pop_front());
    if (exp_spur) err_m = 1'b1;
    if (exp_hs) begin
      owner_q.push_back(exp_sel);
      last_granted = exp_sel;
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [1:0] req, input logic gnt, input logic rv,
                      input logic [DW-1:0] rdata);
    drive(req, gnt, rv, rdata);
    advance();
  endtask

  task automatic do_reset();
    m_req_i    = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    rst_ni     = 1'b0;
    owner_q.delete();
    last_granted = -1;
    err_m        = 1'b0;
    #1;
    check("rst_s_req",    s_req_o,    1'b0);
    check("rst_m_gnt",    m_gnt_o,    2'b00);
    check("rst_m_rvalid", m_rvalid_o, 2'b00);
    check("rst_err",      err_o,      1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_ni = 1'b0;
    rand_payload();
    do_reset();

    // Single master request, response on the next cycle.
    rand_payload();
    m_addr_i[0] = 32'h100;
    drive(2'b01, 1'b1, 1'b0, '0);
    check("single_gnt",  m_gnt_o,  2'b01);
    check("single_addr", s_addr_o, 32'h100);
    advance();
    drive(2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
    check("single_rvalid", m_rvalid_o, 2'b01);
    check("single_rdata",  m_rdata_o,  32'hDEADBEEF);
    advance();

    // Tie after reset alternates starting with master 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      drive(2'b11, 1'b1, (i > 0), $urandom);
      check("tie_gnt", m_gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      advance();
    end
    step(2'b00, 1'b0, 1'b1, $urandom);

    // Backpressure: full FIFO blocks, a pop does not bypass the block.
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b01, 1'b1, 1'b0, '0);
    drive(2'b01, 1'b1, 1'b0, '0);
    check("bp_full_req", s_req_o, 1'b0);
    advance();
    drive(2'b01, 1'b1, 1'b1, 32'h55);
    check("bp_pop_req", s_req_o, 1'b0);
    advance();
    drive(2'b01, 1'b1, 1'b0, '0);
    check("bp_resume_req", s_req_o, 1'b1);
    advance();
    step(2'b00, 1'b0, 1'b1, $urandom);
    step(2'b00, 1'b0, 1'b1, $urandom);

    // Ordering: instr then data, responses return to them in that order.
    step(2'b10, 1'b1, 1'b0, '0);
    step(2'b01, 1'b1, 1'b0, '0);
    drive(2'b00, 1'b0, 1'b1, 32'h1);
    check("order_first", m_rvalid_o, 2'b10);
    advance();
    drive(2'b00, 1'b0, 1'b1, 32'h2);
    check("order_second", m_rvalid_o, 2'b01);
    advance();

    // Simultaneous push and pop with one outstanding.
    step(2'b10, 1'b1, 1'b0, '0);
    drive(2'b01, 1'b1, 1'b1, 32'hA);
    check("pp_rvalid_old", m_rvalid_o, 2'b10);
    check("pp_gnt",        m_gnt_o,    2'b01);
    advance();
    drive(2'b00, 1'b0, 1'b1, 32'hB);
    check("pp_rvalid_new", m_rvalid_o, 2'b01);
    advance();
    drive(2'b00, 1'b0, 1'b0, '0);
    check("pp_drained", m_rvalid_o, 2'b00);
    advance();

    // Randomized traffic against the model, then drain.
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      step(2'($urandom), 1'($urandom), (owner_q.size() > 0) && 1'($urandom), $urandom);
    end
    for (int i = 0; i < MAXO && owner_q.size() > 0; i++) begin
      step(2'b00, 1'b0, 1'b1, $urandom);
    end

    // Spurious response sets a sticky error cleared only by reset.
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 32'hBAD);
    check("spur_rvalid", m_rvalid_o, 2'b00);
    check("spur_err_now", err_o, 1'b0);
    advance();
    drive(2'b00, 1'b0, 1'b0, '0);
    check("spur_err_set", err_o, 1'b1);
    advance();
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b00, 1'b0, 1'b1, $urandom);
    drive(2'b00, 1'b0, 1'b0, '0);
    check("spur_err_held", err_o, 1'b1);
    advance();
    do_reset();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
